// File: rtl/serial_add_sub_if.sv
// Operand/opcode request and result/flag bundle for the bit-serial adder/subtractor.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             Overflow;
  logic             Zero;

  modport master (
    output start, op, A, B,
    input  ready, busy, done, Result, Carry, Overflow, Zero
  );

  modport slave (
    input  start, op, A, B,
    output ready, busy, done, Result, Carry, Overflow, Zero
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder step per clock, LSB first,
// result reassembled in parallel with carry/overflow/zero flags.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    cnt;
  logic             c;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;

  logic             s;
  logic             cout;
  logic [WIDTH-1:0] r_next;

  // Single-bit full adder on the current LSB pair and the held carry.
  always_comb begin
    s      = a_sh[0] ^ b_sh[0] ^ c;
    cout   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    r_next = {s, r_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      c        <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.A;
            b_sh  <= bus.op ? ~bus.B : bus.B;
            c     <= bus.op;
            cnt   <= '0;
            r_sh  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          r_sh <= r_next;
          c    <= cout;
          cnt  <= cnt + 1'b1;
          // MSB step: c still holds the carry into the sign bit here.
          if (cnt == LAST) begin
            result_q <= r_next;
            carry_q  <= cout;
            ovf_q    <= c ^ cout;
            zero_q   <= (r_next == '0);
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.Result   = result_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;
  assign bus.Zero     = zero_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: hand-computed add/subtract vectors,
// ignored start during RUN, back-to-back accept and mid-RUN reset.
module tb_serial_add_sub;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.ready && n < 30) begin
      tick();
      n++;
    end
    if (!bus.ready) check({tag, "_ready_timeout"}, 32'(bus.ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic ev, input logic ez);
    int lat;
    wait_ready(tag);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.A     = ~a;
    bus.B     = 8'hA5;
    check({tag, "_accept_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(WIDTH));
    check({tag, "_result"}, 32'(bus.Result), 32'(er));
    check({tag, "_carry"}, 32'(bus.Carry), 32'(ec));
    check({tag, "_ovf"}, 32'(bus.Overflow), 32'(ev));
    check({tag, "_zero"}, 32'(bus.Zero), 32'(ez));
    tick();
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int ndone;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_flags", {24'd0, bus.Result, bus.Carry, bus.Overflow, bus.Zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("add",     1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0);
    run_op("addwrap", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("addovf",  1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("subneg",  1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("subovf",  1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("subeq",   1'b1, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1);

    // start pulsed mid-RUN with different operands must be ignored
    wait_ready("ign");
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 8'h3C; bus.B = 8'h0F;
    tick();
    bus.start = 1'b0;
    repeat (2) tick();
    bus.start = 1'b1; bus.op = 1'b1; bus.A = 8'hFF; bus.B = 8'h77;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        ndone++;
        check("ign_result", 32'(bus.Result), 32'h4B);
        check("ign_carry", 32'(bus.Carry), 32'd0);
      end
      tick();
    end
    check("ign_ndone", 32'(ndone), 32'd1);
    check("ign_ready", 32'(bus.ready), 32'd1);

    // back-to-back: two operations, second start presented as soon as ready rises
    run_op("b2b_a", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op("b2b_b", 1'b0, 8'h20, 8'h13, 8'h33, 1'b0, 1'b0, 1'b0);

    // reset at RUN cycle 4
    wait_ready("rst");
    bus.start = 1'b1; bus.op = 1'b0; bus.A = 8'h0F; bus.B = 8'h01;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", 32'(bus.ready), 32'd1);
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_flags", {24'd0, bus.Result, bus.Carry, bus.Overflow, bus.Zero}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) ndone++;
    end
    check("rstmid_nodone", 32'(ndone), 32'd0);
    check("rstmid_ready_after", 32'(bus.ready), 32'd1);
    run_op("postrst", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
